// File: rtl/bus_memory.sv
// Byte-addressable little-endian memory behind a simple request/response bus.
// After reset every word is swept to INIT_WORD, one word per cycle. Each
// accepted request then takes WAIT_STATES extra cycles before it commits,
// and a one-cycle response strobe follows.
module bus_memory #(
  parameter int          NUM_BYTES   = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] INIT_WORD   = 32'hE1A00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        init_busy
);

  localparam int             WORDS     = NUM_BYTES / 4;
  localparam int             AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [AW-1:0]  LAST_IDX  = AW'(WORDS - 1);
  localparam logic [3:0]     LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_cnt;
  logic          r_write;
  logic [1:0]    r_size;
  logic          r_signed;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_rsp_error;
  logic [31:0]   r_mem [WORDS];

  logic          w_hs;
  logic          w_commit;
  logic          w_a_write;
  logic [1:0]    w_a_size;
  logic          w_a_signed;
  logic [31:0]   w_a_addr;
  logic [31:0]   w_a_wdata;
  logic [2:0]    w_bytes;
  logic [32:0]   w_end;
  logic          w_err;
  logic [AW-1:0] w_widx;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_rdata;
  logic [3:0]    w_be;
  logic [31:0]   w_wbytes;

  assign req_ready = (r_state == ST_IDLE) && !reset;
  assign init_busy = (r_state == ST_INIT) || reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

  assign w_hs = req_valid && req_ready;

  // With zero wait states the access commits on the handshake edge itself, so
  // the access fields come straight from the inputs while still in IDLE.
  assign w_a_write  = (r_state == ST_IDLE) ? req_write  : r_write;
  assign w_a_size   = (r_state == ST_IDLE) ? req_size   : r_size;
  assign w_a_signed = (r_state == ST_IDLE) ? req_signed : r_signed;
  assign w_a_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
  assign w_a_wdata  = (r_state == ST_IDLE) ? req_wdata  : r_wdata;

  assign w_commit = !reset &&
                    (((r_state == ST_IDLE) && w_hs && (WAIT_STATES == 0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == LAST_WAIT)));

  // Access decode: size, range/alignment error, byte lanes, read extraction
  always_comb begin
    case (w_a_size)
      2'b00:   w_bytes = 3'd1;
      2'b01:   w_bytes = 3'd2;
      default: w_bytes = 3'd4;
    endcase
    w_end  = {1'b0, w_a_addr} + {30'b0, w_bytes};
    w_err  = (w_a_size == 2'b11) ||
             ((w_a_size == 2'b01) && w_a_addr[0]) ||
             ((w_a_size == 2'b10) && (w_a_addr[1:0] != 2'b00)) ||
             (w_end > 33'(NUM_BYTES));
    w_widx  = w_a_addr[AW+1:2];
    w_word  = r_mem[w_widx];
    w_shift = w_word >> {w_a_addr[1:0], 3'b000};
    case (w_a_size)
      2'b00: begin
        w_rdata  = {{24{w_a_signed & w_shift[7]}}, w_shift[7:0]};
        w_be     = 4'b0001 << w_a_addr[1:0];
        w_wbytes = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_rdata  = {{16{w_a_signed & w_shift[15]}}, w_shift[15:0]};
        w_be     = w_a_addr[1] ? 4'b1100 : 4'b0011;
        w_wbytes = {2{w_a_wdata[15:0]}};
      end
      default: begin
        w_rdata  = w_word;
        w_be     = 4'b1111;
        w_wbytes = w_a_wdata;
      end
    endcase
  end

  // Control FSM, request capture and response strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_INIT;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_hs) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= '0;
            r_state  <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_WAIT) r_state <= ST_RESP;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_commit) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= w_err;
        r_rsp_rdata <= (w_err || w_a_write) ? 32'h0 : w_rdata;
      end
    end
  end

  // Storage: initialisation sweep, then byte-lane writes at commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == ST_INIT) begin
        r_mem[r_idx] <= INIT_WORD;
      end else if (w_commit && w_a_write && !w_err) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wbytes[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_memory.sv
// Self-checking bench for bus_memory: directed vector table, randomized
// accesses against a byte-array reference model, reset and throughput cases.
module tb_bus_memory;

  localparam int NB = 64;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_error, init_busy;
  logic [31:0] rsp_rdata;

  logic        t_valid, t_write, t_signed;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_wdata;
  logic        r0_ready, v0, e0, b0, r3_ready, v3, e3, b3;
  logic [31:0] d0, d3;

  bus_memory #(.NUM_BYTES(NB), .WAIT_STATES(1), .INIT_WORD(32'hE1A00000)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .init_busy(init_busy));

  bus_memory #(.NUM_BYTES(NB), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(t_valid), .req_ready(r0_ready),
    .req_write(t_write), .req_size(t_size), .req_signed(t_signed),
    .req_addr(t_addr), .req_wdata(t_wdata), .rsp_valid(v0),
    .rsp_rdata(d0), .rsp_error(e0), .init_busy(b0));

  bus_memory #(.NUM_BYTES(NB), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(t_valid), .req_ready(r3_ready),
    .req_write(t_write), .req_size(t_size), .req_signed(t_signed),
    .req_addr(t_addr), .req_wdata(t_wdata), .rsp_valid(v3),
    .rsp_rdata(d3), .rsp_error(e3), .init_busy(b3));

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mdl [NB];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mdl_init();
    logic [31:0] iw;
    iw = 32'hE1A00000;
    for (int i = 0; i < NB; i++) mdl[i] = iw[8*(i%4) +: 8];
  endtask

  // Reference: byte-array semantics straight from the access rules
  task automatic mdl_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er);
    int n;
    longint unsigned ea;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ea = {32'b0, a} + longint'(n);
    er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (ea > NB);
    rd = 32'h0;
    if (!er) begin
      if (w) begin
        for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8*i));
        if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int t;
    logic [31:0] rnd;
    rd = 32'h0; er = 1'b0; lat = -1;
    t = 0;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    rnd = $urandom;
    req_valid = 1'b0; req_write = rnd[0]; req_size = rnd[2:1]; req_signed = rnd[3];
    req_addr = $urandom; req_wdata = $urandom;
    t = 0;
    while (!rsp_valid && t < 100) begin
      chk("idle_rdata", rsp_rdata, 32'h0);
      chk("idle_error", {31'b0, rsp_error}, 32'h0);
      @(posedge clk); #1; t++;
    end
    if (!rsp_valid) begin chk("rsp_timeout", 32'd0, 32'd1); return; end
    rd = rsp_rdata; er = rsp_error; lat = t;
    @(posedge clk); #1;
    chk("valid_one_cycle", {31'b0, rsp_valid}, 32'h0);
    chk("post_rsp_rdata", rsp_rdata, 32'h0);
  endtask

  task automatic do_reset(input int cyc);
    int n;
    reset = 1'b1;
    repeat (cyc) begin
      @(posedge clk); #1;
      chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
    end
    chk("rst_ready", {31'b0, req_ready}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_error", {31'b0, rsp_error}, 32'h0);
    chk("rst_busy", {31'b0, init_busy}, 32'h1);
    reset = 1'b0;
    n = 0;
    while (init_busy && n < 100) begin n++; @(posedge clk); #1; end
    chk("sweep_len", n, 32'd16);
    chk("ready_after_init", {31'b0, req_ready}, 32'h1);
    mdl_init();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, md, rnd;
    logic        er, me;
    int          lat;
    int          q0[$];
    int          q3[$];

    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h00,       32'h0,        32'hE1A00000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h3C,       32'h0,        32'hE1A00000, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h08,       32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h08,       32'h0,        32'h44,       1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h09,       32'h0,        32'h33,       1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h0A,       32'h0,        32'h22,       1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h0B,       32'h0,        32'h11,       1'b0};
    tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h0C,       32'hABCDEF80, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 32'h0C,       32'h0,        32'hFFFFFF80, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h0C,       32'h0,        32'h00000080, 1'b0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h0E,       32'h1234BEEF, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 2'd1, 1'b1, 32'h0E,       32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[12] = '{1'b0, 2'd1, 1'b0, 32'h0E,       32'h0,        32'h0000BEEF, 1'b0};
    tbl[13] = '{1'b0, 2'd2, 1'b1, 32'h0C,       32'h0,        32'hBEEF0080, 1'b0};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'h02,       32'h0,        32'h0,        1'b1};
    tbl[15] = '{1'b0, 2'd1, 1'b0, 32'h05,       32'h0,        32'h0,        1'b1};
    tbl[16] = '{1'b0, 2'd3, 1'b0, 32'h00,       32'h0,        32'h0,        1'b1};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h3E,       32'h0,        32'h0,        1'b1};
    tbl[18] = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};
    tbl[19] = '{1'b1, 2'd2, 1'b0, 32'h02,       32'hDEADBEEF, 32'h0,        1'b1};
    tbl[20] = '{1'b1, 2'd0, 1'b0, 32'h40,       32'h000000AA, 32'h0,        1'b1};
    tbl[21] = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h12345678, 32'h0,        1'b1};
    tbl[22] = '{1'b0, 2'd2, 1'b0, 32'h00,       32'h0,        32'hE1A00000, 1'b0};
    tbl[23] = '{1'b0, 2'd2, 1'b0, 32'h08,       32'h0,        32'h11223344, 1'b0};
    tbl[24] = '{1'b0, 2'd0, 1'b0, 32'h3F,       32'h0,        32'h000000E1, 1'b0};
    tbl[25] = '{1'b0, 2'd1, 1'b1, 32'h3E,       32'h0,        32'hFFFFE1A0, 1'b0};
    tbl[26] = '{1'b0, 2'd2, 1'b0, 32'h3C,       32'h0,        32'hE1A00000, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    t_valid = 1'b0; t_write = 1'b0; t_size = 2'd2; t_signed = 1'b0;
    t_addr = 32'h0; t_wdata = 32'h0;
    mdl_init();

    do_reset(3);

    // Directed vectors
    foreach (tbl[i]) begin
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, er, lat);
      mdl_access(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, md, me);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_error", i), {31'b0, er}, {31'b0, tbl[i].er});
      chk($sformatf("tbl%0d_latency", i), lat, 32'd1);
    end

    // Randomized accesses against the model
    for (int i = 0; i < 150; i++) begin
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      rnd = $urandom;
      w = rnd[0]; sg = rnd[1]; sz = rnd[3:2];
      a = (rnd[6:4] == 3'd0) ? $urandom : 32'($urandom_range(0, 71));
      wd = $urandom;
      do_req(w, sz, sg, a, wd, rd, er, lat);
      mdl_access(w, sz, sg, a, wd, md, me);
      chk($sformatf("rnd%0d_rdata a=%h sz=%0d w=%0d", i, a, sz, w), rd, md);
      chk($sformatf("rnd%0d_error", i), {31'b0, er}, {31'b0, me});
    end

    // Reset during the wait cycle of a write drops it and re-sweeps memory
    begin
      int t;
      t = 0;
      while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
      chk("rst_wait_ready", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h55667788;
      @(posedge clk); #1;
      req_valid = 1'b0;
      do_reset(2);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat);
      chk("rst_wait_read", rd, 32'hE1A00000);
      chk("rst_wait_err", {31'b0, er}, 32'h0);
    end

    // Back-to-back throughput with req_valid held high
    t_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (r0_ready) q0.push_back(c);
      if (r3_ready) q3.push_back(c);
      @(posedge clk); #1;
    end
    t_valid = 1'b0;
    chk("tput_ws0_count", (q0.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    chk("tput_ws3_count", (q3.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (q0.size() >= 4)
      for (int i = 1; i < 4; i++) chk($sformatf("tput_ws0_gap%0d", i), q0[i] - q0[i-1], 32'd2);
    if (q3.size() >= 4)
      for (int i = 1; i < 4; i++) chk($sformatf("tput_ws3_gap%0d", i), q3[i] - q3[i-1], 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
